clock_timekeeper: RTL

Parametrised, single-clock successor to the digital-clock interface. It keeps hours/minutes/seconds with configurable moduli and advances time on a synchronous 1 Hz enable. A mode/add/sub button FSM edits the time, with edge detection, auto-repeat and up/down wrap. Drives BCD digit pairs, a blink mask and a 12/24 h indication to the display-driver block.

---
 rtl/clock_timekeeper.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/clock_timekeeper.sv
// Time-of-day keeper: H/M/S counters on a 1 Hz enable, button-driven edit FSM
// with auto-repeat, and registered BCD/blink/12h outputs for the display driver.
module clock_timekeeper #(
  parameter int unsigned H_MOD     = 24,
  parameter int unsigned M_MOD     = 60,
  parameter int unsigned S_MOD     = 60,
  parameter int unsigned RPT_DELAY = 50_000_000,
  parameter int unsigned RPT_RATE  = 10_000_000,
  parameter int unsigned CNT_W     = 27
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       mode_button,
  input  logic       add_button,
  input  logic       sub_button,
  input  logic       fmt_12h,
  output logic [3:0] h_tens,
  output logic [3:0] h_units,
  output logic [3:0] m_tens,
  output logic [3:0] m_units,
  output logic [3:0] s_tens,
  output logic [3:0] s_units,
  output logic       pm,
  output logic [2:0] edit_sel,
  output logic       day_carry
);

  localparam int unsigned FW = 7;
  localparam logic [FW-1:0]    H_MAX   = FW'(H_MOD - 1);
  localparam logic [FW-1:0]    M_MAX   = FW'(M_MOD - 1);
  localparam logic [FW-1:0]    S_MAX   = FW'(S_MOD - 1);
  localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(RPT_DELAY);
  localparam logic [CNT_W-1:0] RATE_C  = CNT_W'(RPT_RATE);
  localparam bit               FMT12_OK = (H_MOD == 24);

  typedef enum logic [1:0] {RUN = 2'd0, SET_H = 2'd1, SET_M = 2'd2, SET_S = 2'd3} state_t;

  state_t           state_q, state_d;
  logic [FW-1:0]    hrs_q, hrs_d, min_q, min_d, sec_q, sec_d;
  logic             phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rpt_on_q, rpt_on_d;
  logic             mode_prev_q, add_prev_q, sub_prev_q;
  logic [7:0]       h_bcd_q, h_bcd_d, m_bcd_q, m_bcd_d, s_bcd_q, s_bcd_d;
  logic             pm_q, pm_d, carry_q, carry_d;
  logic [2:0]       edit_sel_q, edit_sel_d;

  logic             mode_press, sel_press, step;
  logic [FW-1:0]    hdisp;

  function automatic logic [FW-1:0] wrap_step(input logic [FW-1:0] v, input logic up,
                                              input logic [FW-1:0] vmax);
    if (up) return (v == vmax) ? '0 : v + FW'(1);
    return (v == '0) ? vmax : v - FW'(1);
  endfunction

  function automatic logic [7:0] to_bcd(input logic [FW-1:0] v);
    return {4'(v / FW'(10)), 4'(v % FW'(10))};
  endfunction

  always_comb begin
    state_d    = state_q;
    hrs_d      = hrs_q;
    min_d      = min_q;
    sec_d      = sec_q;
    phase_d    = phase_q ^ tick_1hz;
    cnt_d      = cnt_q;
    rpt_on_d   = rpt_on_q;
    carry_d    = 1'b0;
    step       = 1'b0;
    mode_press = mode_button & ~mode_prev_q;
    sel_press  = add_button ? ~add_prev_q : (sub_button & ~sub_prev_q);

    // Run counting, or step arbitration for the field being edited
    if (state_q == RUN) begin
      cnt_d    = '0;
      rpt_on_d = 1'b0;
      if (tick_1hz) begin
        if (sec_q == S_MAX) begin
          sec_d = '0;
          if (min_q == M_MAX) begin
            min_d = '0;
            if (hrs_q == H_MAX) begin
              hrs_d   = '0;
              carry_d = 1'b1;
            end else begin
              hrs_d = hrs_q + FW'(1);
            end
          end else begin
            min_d = min_q + FW'(1);
          end
        end else begin
          sec_d = sec_q + FW'(1);
        end
      end
    end else if (mode_press || (add_button == sub_button)) begin
      cnt_d    = '0;
      rpt_on_d = 1'b0;
    end else if (sel_press) begin
      step     = 1'b1;
      cnt_d    = CNT_W'(1);
      rpt_on_d = 1'b0;
    end else if (cnt_q == (rpt_on_q ? RATE_C : DELAY_C)) begin
      step     = 1'b1;
      cnt_d    = CNT_W'(1);
      rpt_on_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (step) begin
      case (state_q)
        SET_H:   hrs_d = wrap_step(hrs_q, add_button, H_MAX);
        SET_M:   min_d = wrap_step(min_q, add_button, M_MAX);
        SET_S:   sec_d = wrap_step(sec_q, add_button, S_MAX);
        default: ;
      endcase
    end

    if (mode_press) begin
      case (state_q)
        RUN:     state_d = SET_H;
        SET_H:   state_d = SET_M;
        SET_M:   state_d = SET_S;
        default: state_d = RUN;
      endcase
    end

    // Display: 12 h remap leaves the 24 h storage untouched
    hdisp = hrs_q;
    pm_d  = 1'b0;
    if (FMT12_OK && fmt_12h) begin
      pm_d = (hrs_q >= FW'(12));
      if (hrs_q == '0)             hdisp = FW'(12);
      else if (hrs_q > FW'(12))    hdisp = hrs_q - FW'(12);
    end
    h_bcd_d = (phase_q && state_q == SET_H) ? 8'hFF : to_bcd(hdisp);
    m_bcd_d = (phase_q && state_q == SET_M) ? 8'hFF : to_bcd(min_q);
    s_bcd_d = (phase_q && state_q == SET_S) ? 8'hFF : to_bcd(sec_q);

    case (state_q)
      SET_H:   edit_sel_d = 3'b100;
      SET_M:   edit_sel_d = 3'b010;
      SET_S:   edit_sel_d = 3'b001;
      default: edit_sel_d = 3'b000;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      hrs_q       <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      phase_q     <= 1'b0;
      cnt_q       <= '0;
      rpt_on_q    <= 1'b0;
      mode_prev_q <= 1'b0;
      add_prev_q  <= 1'b0;
      sub_prev_q  <= 1'b0;
      h_bcd_q     <= '0;
      m_bcd_q     <= '0;
      s_bcd_q     <= '0;
      pm_q        <= 1'b0;
      carry_q     <= 1'b0;
      edit_sel_q  <= '0;
    end else begin
      state_q     <= state_d;
      hrs_q       <= hrs_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      rpt_on_q    <= rpt_on_d;
      mode_prev_q <= mode_button;
      add_prev_q  <= add_button;
      sub_prev_q  <= sub_button;
      h_bcd_q     <= h_bcd_d;
      m_bcd_q     <= m_bcd_d;
      s_bcd_q     <= s_bcd_d;
      pm_q        <= pm_d;
      carry_q     <= carry_d;
      edit_sel_q  <= edit_sel_d;
    end
  end

  assign h_tens    = h_bcd_q[7:4];
  assign h_units   = h_bcd_q[3:0];
  assign m_tens    = m_bcd_q[7:4];
  assign m_units   = m_bcd_q[3:0];
  assign s_tens    = s_bcd_q[7:4];
  assign s_units   = s_bcd_q[3:0];
  assign pm        = pm_q;
  assign edit_sel  = edit_sel_q;
  assign day_carry = carry_q;

endmodule
